// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
package mem_arb_pkg;

  // Which requester the RAM read data belongs to in the cycle after a grant.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_e;

  // Width of the fetch starvation counter; covers STARVE_LIMIT up to 15.
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of one single-port, byte-write RAM with a
// 1-cycle registered read. The data port (D) has fixed priority over the
// instruction-fetch port (I); a starvation counter force-grants I after
// STARVE_LIMIT consecutive D grants while I waits. Read data is routed to
// the requester granted in the previous cycle.
//
// Optional feature, enabled by defining MEM_ARB_LOCK_EN: a D access with
// d_lock=1 keeps the RAM owned by D (I is blocked, even when forced) until a
// later D access with d_lock=0, so the LSU can do atomic read-modify-write.
// Without the macro d_lock is ignored and no lock state exists.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DATA_DEPTH   = 4096,
  parameter int ADDR_WIDTH   = $clog2(DATA_DEPTH),
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  // instruction fetch port
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_gnt,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  // load/store port
  input  logic                    d_req,
  input  logic [DATA_WIDTH/8-1:0] d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic                    d_lock,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  // RAM side
  output logic                    ram_en,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  owner_e                  owner_q, owner_d;
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  logic                    force_i;

`ifdef MEM_ARB_LOCK_EN
  logic lock_q, lock_d;
`else
  logic unused_d_lock;
  assign unused_d_lock = d_lock;
`endif

  // Grant: at most one requester per cycle, D first unless I is starving.
  always_comb begin
    force_i = i_req && (starve_q == LIMIT);
`ifdef MEM_ARB_LOCK_EN
    i_gnt   = i_req && (!d_req || force_i) && !lock_q;
`else
    i_gnt   = i_req && (!d_req || force_i);
`endif
    d_gnt   = d_req && !i_gnt;
  end

  // RAM drive from the winning requester; fetches never write.
  always_comb begin
    ram_en   = i_gnt || d_gnt;
    ram_we   = '0;
    ram_addr = i_addr;
    ram_din  = d_wdata;
    if (d_gnt) begin
      ram_we   = d_we;
      ram_addr = d_addr;
    end
  end

  // Next response owner and starvation count.
  always_comb begin
    owner_d  = OWN_NONE;
    starve_d = starve_q;
    if (i_gnt)      owner_d = OWN_I;
    else if (d_gnt) owner_d = OWN_D;

    // Only consecutive D wins against a waiting fetch count; the count holds
    // at the limit when a lock keeps I from taking its forced grant.
    if (i_gnt || !i_req)   starve_d = '0;
    else if (d_gnt)        starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 1'b1;
  end

  // Response owner and starvation counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

`ifdef MEM_ARB_LOCK_EN
  // Lock follows d_lock of every D grant and persists while D is idle.
  always_comb begin
    lock_d = lock_q;
    if (d_gnt) lock_d = d_lock;
  end

  // Lock register.
  always_ff @(posedge clk) begin
    if (rst) lock_q <= 1'b0;
    else     lock_q <= lock_d;
  end
`endif

  // Responses: rvalid follows the registered owner. It is also masked while
  // rst is high so a response in flight when reset hits never shows up.
  always_comb begin
    i_rvalid = (owner_q == OWN_I) && !rst;
    d_rvalid = (owner_q == OWN_D) && !rst;
    i_rdata  = ram_dout;
    d_rdata  = ram_dout;
  end

  // Byte enables must tile the word exactly.
  if (BE_W * 8 != DATA_WIDTH) begin : g_bad_width
    logic unused_bad_data_width;
    assign unused_bad_data_width = 1'b1;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized phase, all compared against a behavioural model (shadow RAM,
// integer starvation count, pending-response record).
module tb_mem_arbiter;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);
  localparam int BE    = DW / 8;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_lock, d_gnt, d_rvalid;
  logic [BE-1:0] d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          ram_en;
  logic [BE-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Environment RAM: read-first, byte write enables, registered read.
  logic          ram_clr;
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      ram_dout <= '0;
    end else if (ram_en) begin
      ram_dout <= mem[ram_addr];
      for (int b = 0; b < BE; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end
  end

  // Reference model state.
  logic [DW-1:0] shadow [DEPTH];
  int            cnt;          // consecutive D wins while I waited
  bit            lck;
  int            pend_owner;   // 0 none, 1 I, 2 D
  logic [DW-1:0] pend_data;
  bit            dut_ig, dut_dg;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: inputs already driven (low phase). Checks the response
  // of the previous grant, this cycle's grant and RAM drive, then advances
  // the model to the next cycle.
  task automatic step();
    bit fi, ig, dg;
    #1;
    chk("i_rvalid", DW'(i_rvalid), DW'(pend_owner == 1 && !rst));
    chk("d_rvalid", DW'(d_rvalid), DW'(pend_owner == 2 && !rst));
    if (pend_owner == 1 && !rst) chk("i_rdata", i_rdata, pend_data);
    if (pend_owner == 2 && !rst) chk("d_rdata", d_rdata, pend_data);

    fi = i_req && (cnt == LIMIT);
    ig = i_req && (!d_req || fi) && !lck;
    dg = d_req && !ig;
    dut_ig = i_gnt;
    dut_dg = d_gnt;
    chk("i_gnt", DW'(i_gnt), DW'(ig));
    chk("d_gnt", DW'(d_gnt), DW'(dg));
    chk("ram_en", DW'(ram_en), DW'(ig || dg));

    pend_owner = 0;
    if (ig) begin
      chk("ram_addr_i", DW'(ram_addr), DW'(i_addr));
      chk("ram_we_i", DW'(ram_we), '0);
      pend_owner = 1;
      pend_data  = shadow[i_addr];
    end else if (dg) begin
      chk("ram_addr_d", DW'(ram_addr), DW'(d_addr));
      chk("ram_we_d", DW'(ram_we), DW'(d_we));
      if (d_we != '0) chk("ram_din", ram_din, d_wdata);
      pend_owner = 2;
      pend_data  = shadow[d_addr];
      for (int b = 0; b < BE; b++)
        if (d_we[b]) shadow[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
    end else begin
      chk("ram_we_idle", DW'(ram_we), '0);
    end

    if (rst) begin
      pend_owner = 0;
      cnt = 0;
      lck = 1'b0;
    end else begin
      if (ig || !i_req)  cnt = 0;
      else if (dg)       cnt = (cnt == LIMIT) ? LIMIT : cnt + 1;
`ifdef MEM_ARB_LOCK_EN
      if (dg) lck = d_lock;
`endif
    end
    @(negedge clk);
  endtask

  task automatic idle();
    i_req = 1'b0; d_req = 1'b0; d_lock = 1'b0; d_we = '0;
  endtask

  task automatic dwrite(input logic [AW-1:0] a, input logic [DW-1:0] v);
    idle();
    d_req = 1'b1; d_we = '1; d_addr = a; d_wdata = v;
    step();
    idle();
  endtask

  bit pat [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    foreach (shadow[k]) shadow[k] = '0;
    cnt = 0; lck = 1'b0; pend_owner = 0; pend_data = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    idle();
    rst = 1'b1; ram_clr = 1'b1;
    @(negedge clk);
    step(); step();
    ram_clr = 1'b0;
    rst = 1'b0;
    #1;
    chk("reset_i_rvalid", DW'(i_rvalid), '0);
    chk("reset_d_rvalid", DW'(d_rvalid), '0);

    // Preload through the D port.
    dwrite(AW'(6'h10), 32'hDEADBEEF);
    dwrite(AW'(5), 32'hAABBCCDD);
    step();

    // Single fetch: granted same cycle, data next cycle, D silent.
    i_req = 1'b1; i_addr = AW'(6'h10);
    step();
    chk("fetch_gnt", DW'(dut_ig), DW'(1'b1));
    idle();
    #1;
    chk("fetch_rvalid", DW'(i_rvalid), DW'(1'b1));
    chk("fetch_rdata", i_rdata, 32'hDEADBEEF);
    chk("fetch_no_drv", DW'(d_rvalid), '0);
    step();

    // Partial byte write returns the old word, then the merged word reads back.
    d_req = 1'b1; d_we = 4'b0011; d_addr = AW'(5); d_wdata = 32'h11223344;
    step();
    idle();
    #1;
    chk("wr_ack", DW'(d_rvalid), DW'(1'b1));
    chk("wr_old", d_rdata, 32'hAABBCCDD);
    d_req = 1'b1; d_addr = AW'(5);
    step();
    idle();
    #1;
    chk("rd_merged", d_rdata, 32'hAABB3344);
    step();

    // Reset right after a D grant drops its response and the starve count.
    i_req = 1'b1; d_req = 1'b1; d_addr = AW'(3); i_addr = AW'(7);
    step(); step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_drop_rv", DW'(d_rvalid), '0);
    i_req = 1'b1; i_addr = AW'(9);
    step();
    chk("post_rst_igrant", DW'(dut_ig), DW'(1'b1));

    // Both requesting for 10 cycles: four D wins, then a forced fetch.
    i_req = 1'b1; d_req = 1'b1; d_we = '0; d_addr = AW'(5); i_addr = AW'(6'h10);
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("starve_pat%0d", k), DW'(dut_ig), DW'(pat[k]));
    end
    idle();
    step();

    // Fetch request withdrawn before grant issues no access.
    i_req = 1'b1; d_req = 1'b1; d_addr = AW'(2); i_addr = AW'(4);
    step();
    chk("drop_d_wins", DW'(dut_dg), DW'(1'b1));
    i_req = 1'b0; d_req = 1'b0;
    step();
    chk("drop_no_i", DW'(dut_ig), '0);
    step();

`ifdef MEM_ARB_LOCK_EN
    // Locked read-modify-write keeps fetch out until the unlocking write.
    i_req = 1'b1; i_addr = AW'(1);
    d_req = 1'b1; d_lock = 1'b1; d_we = '0; d_addr = AW'(5);
    step();
    chk("lock_rd", DW'(dut_dg), DW'(1'b1));
    d_req = 1'b0; d_lock = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("lock_hold", DW'(dut_ig), '0);
    end
    d_req = 1'b1; d_we = '1; d_wdata = 32'h0BADF00D;
    step();
    chk("unlock_wr", DW'(dut_dg), DW'(1'b1));
    d_req = 1'b0; d_we = '0;
    step();
    chk("unlock_i", DW'(dut_ig), DW'(1'b1));
    idle();
    step();
`endif

    // Randomized traffic honouring the hold-until-grant contract.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!i_req || dut_ig) begin
        i_req  = $urandom_range(0, 1) == 1;
        i_addr = AW'($urandom);
      end else if ($urandom_range(0, 9) == 0) begin
        i_req = 1'b0;
      end
      if (!d_req || dut_dg) begin
        d_req   = $urandom_range(0, 1) == 1;
        d_addr  = AW'($urandom);
        d_wdata = $urandom;
        d_we    = $urandom_range(0, 1) == 1 ? BE'($urandom) : '0;
        d_lock  = $urandom_range(0, 3) == 0;
      end else if ($urandom_range(0, 9) == 0) begin
        d_req = 1'b0;
      end
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing one single-port, byte-write-enable RAM (1-cycle registered read) between the core's instruction-fetch port (I) and load/store port (D).
- Data port has fixed priority over fetch; a starvation counter guarantees fetch progress.
- Responses are routed back to the granted requester one cycle after grant.

Parameters:
- DATA_WIDTH, 32, RAM word width in bits; multiple of 8.
- DATA_DEPTH, 4096, RAM words.
- ADDR_WIDTH, $clog2(DATA_DEPTH), word address width.
- STARVE_LIMIT, 4, consecutive D grants while I is waiting before I is force-granted; range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_req  in  1  fetch request.
- i_addr  in  ADDR_WIDTH  fetch word address.
- i_gnt  out  1  fetch accepted this cycle (combinational).
- i_rvalid  out  1  i_rdata valid (cycle after i_gnt).
- i_rdata  out  DATA_WIDTH  fetch data.
- d_req  in  1  data request.
- d_we  in  DATA_WIDTH/8  byte write enables; 0 means read.
- d_addr  in  ADDR_WIDTH  data word address.
- d_wdata  in  DATA_WIDTH  write data.
- d_lock  in  1  hold ownership after this access (MEM_ARB_LOCK_EN only; ignored otherwise).
- d_gnt  out  1  data accepted this cycle (combinational).
- d_rvalid  out  1  d_rdata valid / write ack (cycle after d_gnt).
- d_rdata  out  DATA_WIDTH  data read result.
- ram_en  out  1  RAM enable.
- ram_we  out  DATA_WIDTH/8  RAM byte write enables.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_din  out  DATA_WIDTH  RAM write data.
- ram_dout  in  DATA_WIDTH  RAM registered read data.

Behaviour:
- Reset: i_rvalid=0, d_rvalid=0, resp_owner=NONE, starve_cnt=0, locked=0. A response pending at reset is dropped; no rvalid is asserted the cycle after reset.
- Grant, combinational, at most one per cycle:
  - force_i = i_req && starve_cnt==STARVE_LIMIT.
  - i_gnt = i_req && (!d_req || force_i) && !locked.
  - d_gnt = d_req && !i_gnt.
- RAM drive:
  - ram_en = i_gnt|d_gnt.
  - On d_gnt: ram_addr=d_addr, ram_we=d_we, ram_din=d_wdata.
  - On i_gnt: ram_addr=i_addr, ram_we=0.
  - With no grant: ram_we=0, ram_en=0, ram_addr don't-care.
- Response, registered:
  - resp_owner <= I / D / NONE from this cycle's grant.
  - i_rvalid = resp_owner==I; d_rvalid = resp_owner==D.
  - i_rdata = d_rdata = ram_dout (unqualified; consumers use rvalid).
  - Latency: grant at cycle N, rvalid at N+1. Back-to-back grants give full throughput.
- Write ack: d_rvalid is asserted for writes too; d_rdata then carries the pre-write word (RAM is read-first).
- Starvation counter (0..STARVE_LIMIT):
  - Increments on d_gnt while i_req=1.
  - Clears on i_gnt or when i_req=0.
  - Saturates at STARVE_LIMIT while locked.
- Requester contract: req/addr/data must be held stable until gnt. Dropping req before gnt is legal and issues no access.
- Simultaneous requests: D wins unless force_i is true.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Defined:
  - d_gnt with d_lock=1 sets locked <= 1.
  - d_gnt with d_lock=0 clears locked.
  - While locked, i_gnt=0 regardless of force_i, giving atomic read-modify-write sequences.
  - Lock persists while d_req=0; releasing it is the LSU's responsibility.
  - rst clears locked.
- Undefined: d_lock is ignored, the locked register is absent, and the i_gnt equation drops the !locked term.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e.
  - STARVE_CNT_W = 4.
- No sub-module; the block is a single module of about 150 lines.

Test Plan:
- Reset then i_req=1, i_addr=0x10, RAM word 0x10=0xDEADBEEF → i_gnt same cycle; i_rvalid=1, i_rdata=0xDEADBEEF next cycle; d_rvalid stays 0.
- d_req and i_req both held high for 10 cycles, STARVE_LIMIT=4 → grant pattern D,D,D,D,I,D,D,D,D,I; responses each one cycle later to the matching port.
- d_we=4'b0011, d_addr=5, d_wdata=0x11223344, old word 0xAABBCCDD → d_rvalid with 0xAABBCCDD; subsequent read of addr 5 returns 0xAABB3344.
- rst asserted the cycle after d_gnt → d_rvalid stays 0 and starve_cnt=0; first post-reset i_req is granted immediately.
- MEM_ARB_LOCK_EN: D read with d_lock=1, 3 idle cycles, D write with d_lock=0, i_req high throughout → i_gnt=0 until the cycle after the unlocking write's grant.
- i_req high 1 cycle then dropped while D is granted → no fetch access; ram_en only asserted for D.
